// File: rtl/baud_rate_generator_frac.sv
// Fractional-N baud tick generator: oversample, bit and mid-bit strobes from a
// runtime-loadable D + F/2^FRAC_WIDTH divisor with shadow-register handshake.
module baud_rate_generator_frac #(
  parameter int unsigned DIV_WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH       = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 651,
  parameter int unsigned DEFAULT_DIV_FRAC = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [DIV_WIDTH-1:0]          i_div_int,
  input  logic [FRAC_WIDTH-1:0]         i_div_frac,
  input  logic                          i_load,
  input  logic                          i_resync,
  output logic                          o_tick,
  output logic                          o_bit_tick,
  output logic                          o_mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_phase,
  output logic                          o_load_pending
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam int unsigned CW = DIV_WIDTH + 1;

  logic [DIV_WIDTH-1:0]  div_int_q, shadow_int_q, next_int;
  logic [FRAC_WIDTH-1:0] div_frac_q, shadow_frac_q, next_frac, acc_q;
  logic                  carry_q, pending_q;
  logic [CW-1:0]         cnt_q, eff_div, period_last;
  logic [PW-1:0]         phase_q;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  tick_q, bit_tick_q, mid_tick_q;
  logic                  terminal, apply;

  always_comb begin
    // Divisors 0 and 1 clamp to 2 so strobes can never be back-to-back.
    eff_div     = (div_int_q < DIV_WIDTH'(2)) ? CW'(2) : {1'b0, div_int_q};
    period_last = eff_div + CW'(carry_q) - CW'(1);
    terminal    = i_enable && !i_resync && (cnt_q == period_last);
    apply       = i_resync || terminal;
    // A load in the applying cycle bypasses the shadow.
    next_int    = i_load ? i_div_int  : shadow_int_q;
    next_frac   = i_load ? i_div_frac : shadow_frac_q;
    acc_sum     = {1'b0, acc_q} + {1'b0, div_frac_q};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      div_int_q     <= DIV_WIDTH'(DEFAULT_DIV_INT);
      div_frac_q    <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      shadow_int_q  <= DIV_WIDTH'(DEFAULT_DIV_INT);
      shadow_frac_q <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      phase_q       <= '0;
      tick_q        <= 1'b0;
      bit_tick_q    <= 1'b0;
      mid_tick_q    <= 1'b0;
    end else begin
      if (i_load) begin
        shadow_int_q  <= i_div_int;
        shadow_frac_q <= i_div_frac;
      end

      if (i_resync) begin
        cnt_q   <= '0;
        acc_q   <= '0;
        carry_q <= 1'b0;
        phase_q <= '0;
      end else if (terminal) begin
        cnt_q            <= '0;
        {carry_q, acc_q} <= acc_sum;
        phase_q          <= phase_q + PW'(1);
      end else if (i_enable) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (apply && (pending_q || i_load)) begin
        div_int_q  <= next_int;
        div_frac_q <= next_frac;
        pending_q  <= 1'b0;
      end else if (i_load) begin
        pending_q <= 1'b1;
      end

      tick_q     <= terminal;
      bit_tick_q <= terminal && (phase_q == PW'(OVERSAMPLE - 1));
      mid_tick_q <= terminal && (phase_q == PW'(OVERSAMPLE / 2 - 1));
    end
  end

  assign o_tick         = tick_q;
  assign o_bit_tick     = bit_tick_q;
  assign o_mid_tick     = mid_tick_q;
  assign o_phase        = phase_q;
  assign o_load_pending = pending_q;

endmodule

// File: tb/tb_baud_rate_generator_frac.sv
// Bench for baud_rate_generator_frac: countdown reference model checked every
// cycle, plus directed interval checks and randomized load/resync/enable traffic.
module tb_baud_rate_generator_frac;

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned PW = 4;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_load = 1'b0;
  logic          i_resync = 1'b0;
  logic [DW-1:0] i_div_int = '0;
  logic [FW-1:0] i_div_frac = '0;
  logic          o_tick, o_bit_tick, o_mid_tick, o_load_pending;
  logic [PW-1:0] o_phase;

  always #5 i_clock = ~i_clock;

  baud_rate_generator_frac dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_div_int      (i_div_int),
    .i_div_frac     (i_div_frac),
    .i_load         (i_load),
    .i_resync       (i_resync),
    .o_tick         (o_tick),
    .o_bit_tick     (o_bit_tick),
    .o_mid_tick     (o_mid_tick),
    .o_phase        (o_phase),
    .o_load_pending (o_load_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: periods tracked as remaining-cycle countdown, fraction as
  // a running sum of sixteenths.
  int m_d, m_f, s_d, s_f, m_left, m_frac, m_phase;
  bit m_pend, e_tick, e_bit, e_mid;
  int cyc, last_tick, n_bit, n_mid;
  int ivals[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp2(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_d = 651; m_f = 1; s_d = 651; s_f = 1; m_pend = 0;
    m_left = 651; m_frac = 0; m_phase = 0;
    e_tick = 0; e_bit = 0; e_mid = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input bit rs, input int li, input int lf);
    bit term, has, extra;
    int nd, nf;
    term   = en && !rs && (m_left == 1);
    has    = m_pend || ld;
    nd     = ld ? li : s_d;
    nf     = ld ? lf : s_f;
    e_tick = term;
    e_bit  = term && (m_phase == 15);
    e_mid  = term && (m_phase == 7);
    if (ld) begin s_d = li; s_f = lf; end
    if (rs) begin
      if (has) begin m_d = nd; m_f = nf; m_pend = 0; end
      else if (ld) m_pend = 1;
      m_frac = 0; m_phase = 0; m_left = clamp2(m_d);
    end else if (term) begin
      m_frac  = m_frac + m_f;
      extra   = (m_frac >= 16);
      m_frac  = m_frac % 16;
      m_phase = (m_phase + 1) % 16;
      if (has) begin m_d = nd; m_f = nf; m_pend = 0; end
      m_left = clamp2(m_d) + int'(extra);
    end else begin
      if (ld) m_pend = 1;
      if (en) m_left--;
    end
  endtask

  task automatic cycle(input bit en, input bit ld, input bit rs, input int li, input int lf);
    i_enable = en; i_load = ld; i_resync = rs;
    i_div_int = DW'(li); i_div_frac = FW'(lf);
    model_step(en, ld, rs, li, lf);
    @(posedge i_clock); #1;
    cyc++;
    check_eq("outputs", {o_tick, o_bit_tick, o_mid_tick, o_load_pending, o_phase},
             {e_tick, e_bit, e_mid, m_pend, PW'(m_phase)});
    if (rs) last_tick = cyc;
    if (o_tick) begin
      ivals.push_back(cyc - last_tick);
      last_tick = cyc;
      n_bit += int'(o_bit_tick);
      n_mid += int'(o_mid_tick);
    end
    i_load = 1'b0; i_resync = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int budget);
    int k = 0;
    while (ivals.size() < n && k < budget) begin
      cycle(1, 0, 0, 0, 0);
      k++;
    end
    check_eq("tick_wait", ivals.size(), n);
  endtask

  task automatic run_to_terminal();
    for (int k = 0; k < 1000 && m_left != 1; k++) cycle(1, 0, 0, 0, 0);
  endtask

  initial begin
    int exp_frac [5] = '{4, 4, 5, 4, 5};
    int n652;
    model_reset();
    cyc = 0; last_tick = 0; n_bit = 0; n_mid = 0;
    #2;
    check_eq("reset_outputs", {o_tick, o_bit_tick, o_mid_tick, o_load_pending, o_phase}, 0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Default divisor 651 + 1/16.
    run_ticks(17, 20000);
    check_eq("first_tick", ivals[0], 651);
    n652 = 0;
    foreach (ivals[i]) if (ivals[i] == 652) n652++;
    check_eq("count_652", n652, 1);
    check_eq("ival17", ivals[16], 652);
    check_eq("bit_ticks", n_bit, 1);
    check_eq("mid_ticks", n_mid, 1);

    // D=4, F=8 from a fresh phase.
    cycle(1, 1, 0, 4, 8);
    cycle(1, 0, 1, 0, 0);
    ivals.delete();
    run_ticks(5, 100);
    foreach (exp_frac[i]) check_eq($sformatf("frac_ival%0d", i), ivals[i], exp_frac[i]);

    // Load D=10 at cnt=2 of a D=4 period.
    cycle(1, 1, 1, 4, 0);
    ivals.delete();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 10, 0);
    check_eq("pending_set", o_load_pending, 1);
    run_ticks(1, 100);
    check_eq("pending_clr", o_load_pending, 0);
    check_eq("cur_period", ivals[0], 4);
    run_ticks(2, 100);
    check_eq("next_period", ivals[1], 10);

    // Load D=1 coincident with terminal: clamp to 2, applies immediately.
    run_to_terminal();
    cycle(1, 1, 0, 1, 0);
    check_eq("bypass_pending", o_load_pending, 0);
    ivals.delete();
    run_ticks(3, 100);
    foreach (ivals[i]) check_eq($sformatf("clamp_ival%0d", i), ivals[i], 2);

    // Resync at cnt=3, phase=2.
    cycle(1, 1, 1, 20, 0);
    ivals.delete();
    run_ticks(2, 200);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    check_eq("resync_phase", o_phase, 0);
    ivals.delete();
    run_ticks(1, 200);
    check_eq("resync_ival", ivals[0], 20);

    // Resync coincident with terminal.
    run_to_terminal();
    cycle(1, 0, 1, 0, 0);
    check_eq("resync_no_tick", o_tick, 0);

    // Enable low for 7 cycles mid-period.
    ivals.delete();
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 0);
    run_ticks(1, 200);
    check_eq("stretch_ival", ivals[0], 27);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
            int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-period with a pending load.
    cycle(1, 1, 0, 9, 3);
    #3 i_reset = 1'b1;
    #1;
    check_eq("async_reset", {o_tick, o_bit_tick, o_mid_tick, o_load_pending, o_phase}, 0);
    model_reset();
    @(negedge i_clock);
    i_reset = 1'b0;
    cyc = 0; last_tick = 0;
    ivals.delete();
    run_ticks(1, 1000);
    check_eq("restart_default", ivals[0], 651);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baud_rate_generator_frac.md
# baud_rate_generator_frac

Programmable fractional-N baud tick generator for the UART datapath. It runs at the system clock and produces three single-cycle strobes: an oversampling tick (OVERSAMPLE per bit), a bit tick, and a mid-bit sample tick. The divisor is loaded at runtime through a shadow-register handshake and never glitches the current period. A resync input lets the RX front end realign phase on a start-bit edge.

## Interface
- DIV_WIDTH, 16: width of the integer divisor.
- FRAC_WIDTH, 4: width of the fractional divisor; resolution is 1/2^FRAC_WIDTH clock.
- OVERSAMPLE, 16: oversampling ticks per bit; power of two, at least 4.
- DEFAULT_DIV_INT, 651: integer divisor after reset (100 MHz, 9600 baud, x16).
- DEFAULT_DIV_FRAC, 1: fractional divisor after reset.
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  count enable; when low, all state holds.
- i_div_int  in  DIV_WIDTH  new integer divisor, sampled when i_load=1.
- i_div_frac  in  FRAC_WIDTH  new fractional divisor, sampled when i_load=1.
- i_load  in  1  one-cycle request to capture i_div_int and i_div_frac into the shadow registers.
- i_resync  in  1  synchronous phase restart.
- o_tick  out  1  oversampling strobe, one cycle wide.
- o_bit_tick  out  1  bit-boundary strobe, coincident with the o_tick that wraps the phase.
- o_mid_tick  out  1  mid-bit strobe, coincident with the o_tick where phase equals OVERSAMPLE/2-1.
- o_phase  out  $clog2(OVERSAMPLE)  current oversample index.
- o_load_pending  out  1  shadow holds a divisor that has not yet been applied.

## Operation
- State:
  - active divisor pair (D, F);
  - shadow pair;
  - cycle counter cnt (DIV_WIDTH+1 bits);
  - fractional accumulator acc (FRAC_WIDTH bits);
  - carry flag;
  - phase counter.
- Period length P = max(D,2) + carry. Divisor values 0 and 1 clamp to 2.
- cnt counts 0..P-1 while i_enable=1. The terminal cycle is cnt==P-1.
- On a terminal cycle:
  - cnt <= 0;
  - {carry, acc} <= acc + F;
  - phase <= phase+1, modulo OVERSAMPLE;
  - the shadow is applied to (D, F) if pending.
- Average tick period is D + F/2^FRAC_WIDTH cycles. The first period after reset or resync is exactly D, since carry=0 and acc=0.
- o_tick is a registered signal equal to (terminal cycle). o_bit_tick is registered as terminal AND phase==OVERSAMPLE-1. o_mid_tick is registered as terminal AND phase==OVERSAMPLE/2-1. o_phase shows the post-increment value in the same cycle the strobes are high.
- Load handshake:
  - i_load sets o_load_pending and overwrites the shadow. The last load before application wins.
  - Application happens on the next terminal cycle. If i_load and a terminal cycle coincide, the newly loaded value applies to the period starting immediately (bypass).
  - o_load_pending clears on application.
- i_resync has priority over terminal and enable:
  - cnt, acc, carry and phase go to 0, and any pending shadow is applied;
  - strobes are 0 in the following cycle;
  - the next o_tick follows D cycles later.
- i_enable=0: cnt, acc, phase and shadow application freeze; strobes are 0; i_load is still captured.
- Reset: (D, F) go to the defaults, and the shadow equals the defaults. cnt, acc, carry, phase, o_tick, o_bit_tick, o_mid_tick, o_phase and o_load_pending all go to 0.

## Timing
- All outputs are registered. Strobes are exactly one cycle wide, and never back-to-back, since P≥2.
- With i_enable=1 from reset release, the first o_tick is high during cycle D after the first rising edge, counting that edge as cycle 1.
- Strobe latency from the terminal cycle is 1 cycle. i_resync affects cnt on the next edge.
- Reset assertion clears the outputs asynchronously, with no clock required. Deassertion is synchronised externally.
- Changing the divisor mid-period never shortens or lengthens the period in progress.

## Test plan
- Reset defaults, enable=1, measure 16 consecutive o_tick intervals -> one 652-cycle interval in every 16, 651 otherwise. o_bit_tick on every 16th o_tick.
- OVERSAMPLE=4, D=4, F=8 -> o_tick intervals 4,4,5,4,5,... o_bit_tick every 4 ticks. o_mid_tick at phase 1. o_phase cycles 1,2,3,0.
- Load D=10 at cnt=2 of a D=4 period -> current period stays 4 cycles, next is 10. o_load_pending high from the load edge until the terminal edge.
- Load coincident with the terminal cycle -> the new divisor governs the very next period. Loading D=1 -> period of 2 cycles (clamp).
- i_resync at cnt=3 with phase=2 -> no strobe, phase=0, next o_tick after D cycles. Resync and terminal in the same cycle -> resync wins, no o_tick.
- Deassert i_enable for 7 cycles mid-period -> the interval stretches by exactly 7, with no strobes. Assert i_reset mid-period -> all outputs 0 immediately, restart with the default divisor.
